seg7_scan: RTL
==============

# seg7_scan

Four-digit multiplexed seven-segment display driver that sits directly downstream of the button-driven counter and consumes its 16-bit `VAL` output. It samples the value once per scan frame so no frame shows a torn value, and drives common-anode digit enables and segment lines. By default it displays hex; an optional build adds a sequential binary-to-BCD converter for decimal display.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each digit is lit; legal range 17..2^20.
- `CLK` in 1: system clock, all state on rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `VAL` in 16: binary value to display (counter output).
- `EN` in 1: display enable; when 0, all digits blank while scanning continues.
- `AN` out 4: digit enables, active-low; `AN[0]` is the rightmost, least-significant digit.
- `SEG` out 7: segments, active-low; `SEG[0]`=a … `SEG[6]`=g.
- `DP` out 1: decimal point, active-low, held 1 (off).
- `FRAME` out 1: one-cycle pulse at each frame boundary.

## Operation
- Prescaler counts 0..SCAN_DIV-1 and wraps. The terminal count is the "tick".
- Digit index `idx` (2 bit) advances 0→1→2→3→0 on each tick.
- A frame boundary is a tick with `idx`==3. On that cycle:
  - `snap` <= `VAL`;
  - `idx` <= 0;
  - `FRAME` is 1 on the following cycle only.
- Hex mode: digit k shows nibble `snap[4k+3:4k]` through the shared font, 0..F.
  - Example: 1 = 7'h79; F = 7'h0E.
- Outputs are registered from the updated `idx`, `snap` and `EN`.
  - `AN` = ~(1<<idx) when `EN`=1, else 4'hF.
  - `SEG` is the font for digit `idx`, or 7'h7F when `EN`=0.
- `EN` is sampled every cycle. Deasserting it blanks the display on the next cycle. Reasserting it resumes at the current `idx`, with no frame restart.
- Reset values:
  - `AN`=4'hF, `SEG`=7'h7F, `DP`=1, `FRAME`=0;
  - prescaler 0, `idx` 0, `snap` 0.
- Reset mid-frame aborts scanning immediately and asynchronously. After release, the first tick occurs SCAN_DIV cycles later.

## Timing
- First `AN`/`SEG` update: one cycle after reset release (digit 0, value 0, if `EN`=1).
- Each digit stays lit exactly SCAN_DIV cycles. The frame period is 4·SCAN_DIV cycles.
- `VAL`→display latency in hex mode:
  - the value is captured at the next frame boundary;
  - it appears on `SEG` one cycle after that boundary.
- `VAL` changes between boundaries never alter the displayed frame.
- `SCAN_DIV` < 17 is a parameter error, checked at elaboration.

## Configuration
- Macro `SEG7_SCAN_BCD_EN`.
- **Defined:**
  - At each frame boundary, the completed BCD result is committed to the display buffer.
  - The converter then restarts with the current `VAL`. It runs a double-dabble of 16 shift cycles plus 1 load cycle, so it always finishes within one frame.
  - Displayed decimal digits therefore lag `VAL` by one full frame.
  - Digits show 0..9.
  - If the captured `VAL` > 9999, all four digits show a dash (only segment g lit, `SEG`=7'h3F).
  - The reset value of the buffer is 0000.
- **Undefined:** hex mode only; no converter logic is present.

## Structure
- Package `seg7_pkg` holds:
  - `NUM_DIGITS`=4;
  - the 16-entry font constant/function (active-low, a at bit 0);
  - `SEG_BLANK`=7'h7F;
  - `SEG_DASH`=7'h3F.
- Sub-module `bin2bcd16` holds the sequential double-dabble converter:
  - inputs: `start`, `bin[15:0]`;
  - outputs: `busy`, `done` pulse, `bcd[15:0]`, `ovf`;
  - it uses the same `CLK` and `RST`;
  - it is instantiated only under `SEG7_SCAN_BCD_EN`.

## Test plan
Benches run with SCAN_DIV=17.
- **Reset:** RST=0 mid-scan → `AN`=4'hF, `SEG`=7'h7F, `DP`=1, `FRAME`=0 immediately, without waiting for a `CLK` edge.
- **Scan cadence:** `EN`=1 → `FRAME` pulses every 68 cycles. `AN` cycles through 1110, 1101, 1011, 0111, each held 17 cycles.
- **Hex:** `VAL`=16'h1A3F → after the first boundary, `AN`=1110 shows `SEG`=7'h0E and `AN`=0111 shows `SEG`=7'h79.
- **Tear-free:** change `VAL` to 16'h0000 while `AN`=1101 → the remaining digits still show 1A3F. Zeros appear after the next `FRAME`.
- **Enable:** `EN`=0 for 30 cycles → `AN`=4'hF and `SEG`=7'h7F. `FRAME` keeps its 68-cycle period, and the display resumes at the current digit.
- **BCD (macro defined):**
  - `VAL`=1234 → digits read 4,3,2,1 (`AN[0]`..`AN[3]`) from the second boundary onward.
  - `VAL`=10000 → all digits `SEG`=7'h3F.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants, font table and helpers for the seg7_scan display driver.
// Optional decimal display is built in when SEG7_SCAN_BCD_EN is defined.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [6:0]  SEG_BLANK  = 7'h7F;
  localparam logic [6:0]  SEG_DASH   = 7'h3F;

  typedef enum logic {
    BCD_IDLE,
    BCD_SHIFT
  } bcd_state_e;

  // Active-low segment pattern for a hex digit; bit 0 is segment a.
  function automatic logic [6:0] seg_font(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Double-dabble correction: every BCD nibble of 5 or more gets +3
  // so that the following left shift carries correctly into the next digit.
  function automatic logic [15:0] bcd_adjust(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int k = 0; k < 4; k++) begin
      if (r[4*k +: 4] >= 4'd5) r[4*k +: 4] = r[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// Display bus: value/enable in from the counter side, digit/segment lines out.
interface seg7_scan_if;
  logic [15:0]                       VAL;
  logic                              EN;
  logic [seg7_pkg::NUM_DIGITS-1:0]   AN;
  logic [6:0]                        SEG;
  logic                              DP;
  logic                              FRAME;

  modport master (output VAL, EN, input AN, SEG, DP, FRAME);
  modport slave  (input VAL, EN, output AN, SEG, DP, FRAME);
endinterface

// File: rtl/bin2bcd16.sv
// Sequential 16-bit binary to 4-digit BCD converter (double dabble):
// one load cycle followed by 16 shift cycles, then a one-cycle done pulse.
// bcd/ovf are only meaningful while done is high.
module bin2bcd16
  import seg7_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd,
  output logic        ovf
);

  bcd_state_e  state_q, state_d;
  logic [15:0] sh_q, sh_d;
  logic [15:0] bits_q, bits_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;
  logic [15:0] adj;

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= BCD_IDLE;
      sh_q    <= '0;
      bits_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bits_q  <= bits_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // Load on start, then shift 16 times; overflow is judged on the raw input.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bits_d  = bits_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    adj     = bcd_adjust(sh_q);
    case (state_q)
      BCD_IDLE: begin
        if (start) begin
          sh_d    = '0;
          bits_d  = bin;
          cnt_d   = '0;
          ovf_d   = (bin > 16'd9999);
          state_d = BCD_SHIFT;
        end
      end
      default: begin
        sh_d   = {adj[14:0], bits_q[15]};
        bits_d = {bits_q[14:0], 1'b0};
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = BCD_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  assign busy = (state_q == BCD_SHIFT);
  assign done = done_q;
  assign bcd  = sh_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed common-anode seven-segment driver. The value is
// snapshotted once per frame so a frame never shows a torn value.
// Define SEG7_SCAN_BCD_EN for decimal display (one frame extra latency).
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
)
(
  input  logic      CLK,
  input  logic      RST,
  seg7_scan_if.slave bus
);

  localparam int unsigned      CNT_W    = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  if (SCAN_DIV < 17 || SCAN_DIV > (1 << 20)) begin : g_bad_div
    $error("seg7_scan: SCAN_DIV must be within 17..2^20");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      snap_q, snap_d, snap_in;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             frame_q;
  logic             dash_d;
  logic             tick, frame_bnd;
  logic [3:0]       nib;

  assign tick      = (cnt_q == CNT_LAST);
  assign frame_bnd = tick && (idx_q == 2'd3);

`ifdef SEG7_SCAN_BCD_EN
  logic        bcd_busy, bcd_done, bcd_ovf;
  logic [15:0] bcd_val, res_q;
  logic        res_ovf_q, dash_q;

  bin2bcd16 u_bin2bcd16 (
    .CLK   (CLK),
    .RST   (RST),
    .start (frame_bnd & ~bcd_busy),
    .bin   (bus.VAL),
    .busy  (bcd_busy),
    .done  (bcd_done),
    .bcd   (bcd_val),
    .ovf   (bcd_ovf)
  );

  // Hold the finished conversion until the next frame boundary commits it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      res_q     <= '0;
      res_ovf_q <= 1'b0;
    end else if (bcd_done) begin
      res_q     <= bcd_val;
      res_ovf_q <= bcd_ovf;
    end
  end

  // Dash flag belongs to the committed frame, like the digit buffer.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) dash_q <= 1'b0;
    else      dash_q <= dash_d;
  end

  assign snap_in = res_q;
  assign dash_d  = frame_bnd ? res_ovf_q : dash_q;
`else
  assign snap_in = bus.VAL;
  assign dash_d  = 1'b0;
`endif

  // Next scan position, frame snapshot and the digit/segment pattern derived
  // from them, so the outputs follow the updated index without an extra lag.
  always_comb begin
    cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d  = tick ? idx_q + 2'd1 : idx_q;
    snap_d = frame_bnd ? snap_in : snap_q;
    nib    = snap_d[{idx_d, 2'b00} +: 4];
    an_d   = 4'hF;
    seg_d  = SEG_BLANK;
    if (bus.EN) begin
      an_d  = ~(4'b0001 << idx_d);
      seg_d = dash_d ? SEG_DASH : seg_font(nib);
    end
  end

  // Scan state and registered display outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      snap_q  <= '0;
      an_q    <= 4'hF;
      seg_q   <= SEG_BLANK;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      frame_q <= frame_bnd;
    end
  end

  assign bus.AN    = an_q;
  assign bus.SEG   = seg_q;
  assign bus.DP    = 1'b1;
  assign bus.FRAME = frame_q;

endmodule
